// File: rtl/trico_credit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : trico_credit_arbiter_if
// Brief    : Credit/done/pop bundle between the root pop logic and the arbiter.
// Revision : 1.0
// ============================================================================
interface trico_credit_arbiter_if #(
    parameter int NUM_RPU = 3,
    parameter int PLW     = 7,
    parameter int CDW     = 16,
    parameter int RID_W   = $clog2(NUM_RPU)
);
    logic                   i_credit_valid;
    logic [RID_W-1:0]       i_credit_rpu;
    logic [PLW-1:0]         i_credit_len;
    logic                   i_done_valid;
    logic [RID_W-1:0]       i_done_rpu;
    logic [PLW-1:0]         i_done_len;
    logic [NUM_RPU-1:0]     i_rpu_nonempty;
    logic [NUM_RPU-1:0]     o_pop;
    logic [RID_W-1:0]       o_pop_rpu;
    logic [NUM_RPU*CDW-1:0] o_credit;
    logic [NUM_RPU-1:0]     o_busy;

    modport master (
        output i_credit_valid, i_credit_rpu, i_credit_len,
        output i_done_valid, i_done_rpu, i_done_len,
        output i_rpu_nonempty,
        input  o_pop, o_pop_rpu, o_credit, o_busy
    );

    modport slave (
        input  i_credit_valid, i_credit_rpu, i_credit_len,
        input  i_done_valid, i_done_rpu, i_done_len,
        input  i_rpu_nonempty,
        output o_pop, o_pop_rpu, o_credit, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/trico_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trico_credit_arbiter
// Brief    : Round-robin, credit-gated pop arbiter for sub-tree RPUs 1..N-1.
//            Optional macro TRICO_CREDIT_SAT_EN: saturate credits instead of wrap.
// Revision : 1.0
// ============================================================================
module trico_credit_arbiter #(
    parameter int NUM_RPU = 3,
    parameter int PLW     = 7,
    parameter int CDW     = 16,
    parameter int RID_W   = $clog2(NUM_RPU)
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    trico_credit_arbiter_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam int         C_NARB  = NUM_RPU - 1;

`ifdef TRICO_CREDIT_SAT_EN
    localparam logic signed [CDW:0] C_SAT_MAX = {2'b00, {(CDW-1){1'b1}}};
    localparam logic signed [CDW:0] C_SAT_MIN = {2'b11, {(CDW-1){1'b0}}};
`endif

    logic [0:0]            state_q  [NUM_RPU];
    logic [0:0]            state_d  [NUM_RPU];
    logic signed [CDW-1:0] credit_q [NUM_RPU];
    logic signed [CDW-1:0] credit_d [NUM_RPU];
    logic [RID_W-1:0]      rr_q, rr_d;
    logic [NUM_RPU-1:0]    pop_q, pop_d;
    logic [RID_W-1:0]      pop_rpu_q, pop_rpu_d;
    logic [NUM_RPU-1:0]    w_elig;
    logic                  w_gnt_vld;
    logic [RID_W-1:0]      w_gnt_idx;

    function automatic logic signed [CDW-1:0] f_update(
        input logic signed [CDW-1:0] cur,
        input logic                  add_en,
        input logic [PLW-1:0]        add_len,
        input logic                  sub_en,
        input logic [PLW-1:0]        sub_len
    );
        logic signed [CDW:0] sum;
        sum = {cur[CDW-1], cur};
        if (add_en) sum = sum + $signed({{(CDW+1-PLW){1'b0}}, add_len});
        if (sub_en) sum = sum - $signed({{(CDW+1-PLW){1'b0}}, sub_len});
`ifdef TRICO_CREDIT_SAT_EN
        if (sum > C_SAT_MAX) sum = C_SAT_MAX;
        if (sum < C_SAT_MIN) sum = C_SAT_MIN;
`endif
        return sum[CDW-1:0];
    endfunction

    always_comb begin
        w_elig = '0;
        for (int i = 1; i < NUM_RPU; i++) begin
            w_elig[i] = (state_q[i] == ST_IDLE) && bus.i_rpu_nonempty[i]
                     && !credit_q[i][CDW-1] && (credit_q[i] != '0);
        end
    end

    // rr_q holds the RPU after the last grant; scan forward from it, skipping RPU 0.
    always_comb begin : arb_scan
        logic [RID_W-1:0] cand;
        cand      = rr_q;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < C_NARB; k++) begin
            if (!w_gnt_vld && w_elig[cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = cand;
            end
            cand = (cand == RID_W'(NUM_RPU-1)) ? RID_W'(1) : cand + RID_W'(1);
        end
    end

    always_comb begin
        rr_d      = rr_q;
        pop_d     = '0;
        pop_rpu_d = '0;
        for (int i = 0; i < NUM_RPU; i++) begin
            state_d[i]  = state_q[i];
            credit_d[i] = credit_q[i];
        end

        if (w_gnt_vld) begin
            pop_d[w_gnt_idx] = 1'b1;
            pop_rpu_d        = w_gnt_idx;
            rr_d = (w_gnt_idx == RID_W'(NUM_RPU-1)) ? RID_W'(1) : w_gnt_idx + RID_W'(1);
        end

        // Index 0 is never visited, so traffic aimed at the root falls through untouched.
        for (int i = 1; i < NUM_RPU; i++) begin
            credit_d[i] = f_update(credit_q[i],
                                   bus.i_credit_valid && (bus.i_credit_rpu == RID_W'(i)),
                                   bus.i_credit_len,
                                   bus.i_done_valid && (bus.i_done_rpu == RID_W'(i)),
                                   bus.i_done_len);
            if (w_gnt_vld && (w_gnt_idx == RID_W'(i))) begin
                state_d[i] = ST_WAIT;
            end else if ((state_q[i] == ST_WAIT) && bus.i_done_valid
                         && (bus.i_done_rpu == RID_W'(i))) begin
                state_d[i] = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < NUM_RPU; i++) begin
                state_q[i]  <= ST_IDLE;
                credit_q[i] <= '0;
            end
            rr_q      <= RID_W'(1);
            pop_q     <= '0;
            pop_rpu_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RPU; i++) begin
                state_q[i]  <= state_d[i];
                credit_q[i] <= credit_d[i];
            end
            rr_q      <= rr_d;
            pop_q     <= pop_d;
            pop_rpu_q <= pop_rpu_d;
        end
    end

    assign bus.o_pop     = pop_q;
    assign bus.o_pop_rpu = pop_rpu_q;

    for (genvar gi = 0; gi < NUM_RPU; gi++) begin : g_out
        assign bus.o_busy[gi]                = (state_q[gi] == ST_WAIT);
        assign bus.o_credit[gi*CDW +: CDW]   = credit_q[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_trico_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trico_credit_arbiter
// Brief    : Directed self-checking bench for trico_credit_arbiter.
// Revision : 1.0
// ============================================================================
module tb_trico_credit_arbiter;
    localparam int NUM_RPU = 3;
    localparam int PLW     = 7;
    localparam int CDW     = 16;
    localparam int RID_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_seq [4] = '{2, 1, 2, 1};

    trico_credit_arbiter_if #(.NUM_RPU(NUM_RPU), .PLW(PLW), .CDW(CDW), .RID_W(RID_W)) bus ();

    trico_credit_arbiter #(.NUM_RPU(NUM_RPU), .PLW(PLW), .CDW(CDW), .RID_W(RID_W)) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] cr(input int i);
        logic signed [CDW-1:0] v;
        v = bus.o_credit[i*CDW +: CDW];
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_credit(input logic v, input int rpu, input int len);
        bus.i_credit_valid = v;
        bus.i_credit_rpu   = RID_W'(rpu);
        bus.i_credit_len   = PLW'(len);
    endtask

    task automatic set_done(input logic v, input int rpu, input int len);
        bus.i_done_valid = v;
        bus.i_done_rpu   = RID_W'(rpu);
        bus.i_done_len   = PLW'(len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_credit(1'b0, 0, 0);
        set_done(1'b0, 0, 0);
        bus.i_rpu_nonempty = '0;

        // Reset must act before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_pop",     bus.o_pop,     0);
        check("rst_pop_rpu", bus.o_pop_rpu, 0);
        check("rst_busy",    bus.o_busy,    0);
        check("rst_credit1", cr(1),         0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // First grant: credit visible one cycle, pop the next.
        bus.i_rpu_nonempty = 3'b010;
        set_credit(1'b1, 1, 10);
        step();
        set_credit(1'b0, 0, 0);
        check("c1_credit",  cr(1),     10);
        check("c1_nopop",   bus.o_pop, 0);
        step();
        check("c1_pop",     bus.o_pop,     3'b010);
        check("c1_pop_rpu", bus.o_pop_rpu, 1);
        check("c1_busy",    bus.o_busy,    3'b010);
        step();
        check("c1_strobe",  bus.o_pop,     0);
        check("c1_wait",    bus.o_busy,    3'b010);

        // Overdraw to -2, then recover with +3.
        set_done(1'b1, 1, 12);
        step();
        set_done(1'b0, 0, 0);
        check("d1_credit", cr(1),      -2);
        check("d1_idle",   bus.o_busy, 0);
        step();
        check("d1_nopop_a", bus.o_pop, 0);
        step();
        check("d1_nopop_b", bus.o_pop, 0);
        set_credit(1'b1, 1, 3);
        step();
        set_credit(1'b0, 0, 0);
        check("d1_credit_pos", cr(1),     1);
        check("d1_nopop_c",    bus.o_pop, 0);
        step();
        check("d1_repop", bus.o_pop, 3'b010);
        set_done(1'b1, 1, 1);
        bus.i_rpu_nonempty = '0;
        step();
        set_done(1'b0, 0, 0);
        check("d1_zero", cr(1),      0);
        check("d1_free", bus.o_busy, 0);

        // Alternation: pointer sits after RPU 1, so RPU 2 goes first.
        set_credit(1'b1, 2, 100);
        step();
        set_credit(1'b1, 1, 100);
        step();
        set_credit(1'b0, 0, 0);
        bus.i_rpu_nonempty = 3'b110;
        step();
        for (int n = 0; n < 4; n++) begin
            check($sformatf("rr_rpu%0d", n), bus.o_pop_rpu, exp_seq[n]);
            check($sformatf("rr_pop%0d", n), bus.o_pop,     1 << exp_seq[n]);
            set_done(1'b1, exp_seq[n], 1);
            step();
        end
        check("rr_rpu4", bus.o_pop_rpu, 2);
        set_done(1'b1, 2, 1);
        bus.i_rpu_nonempty = '0;
        step();
        set_done(1'b0, 0, 0);
        check("rr_quiet",   bus.o_pop,  0);
        check("rr_busy",    bus.o_busy, 0);
        check("rr_credit1", cr(1),      98);
        check("rr_credit2", cr(2),      97);

        // Same-cycle credit and done on RPU 2 from 4.
        set_done(1'b1, 2, 93);
        step();
        check("cd_pre", cr(2), 4);
        set_credit(1'b1, 2, 5);
        set_done(1'b1, 2, 7);
        step();
        check("cd_both", cr(2), 2);

        // Root and out-of-range targets are ignored.
        set_credit(1'b1, 0, 50);
        set_done(1'b1, 3, 9);
        step();
        set_credit(1'b1, 3, 50);
        set_done(1'b1, 0, 9);
        step();
        set_credit(1'b0, 0, 0);
        set_done(1'b0, 0, 0);
        check("ign_credit0", cr(0), 0);
        check("ign_credit1", cr(1), 98);
        check("ign_credit2", cr(2), 2);

        // Upper boundary: 258*127 + 1 = 32767, then +100.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        check("sat_start", cr(1), 0);
        set_credit(1'b1, 1, 127);
        repeat (258) step();
        set_credit(1'b1, 1, 1);
        step();
        check("sat_max", cr(1), 32767);
        set_credit(1'b1, 1, 100);
        step();
        set_credit(1'b0, 0, 0);
`ifdef TRICO_CREDIT_SAT_EN
        check("sat_over", cr(1), 32767);
`else
        check("wrap_over", cr(1), -32669);
`endif

        // Reset while RPU 2 is outstanding discards the pop.
        bus.i_rpu_nonempty = 3'b100;
        set_credit(1'b1, 2, 5);
        step();
        set_credit(1'b0, 0, 0);
        step();
        check("ar_pop",  bus.o_pop,  3'b100);
        check("ar_busy", bus.o_busy, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check("ar_pop0",     bus.o_pop,     0);
        check("ar_pop_rpu0", bus.o_pop_rpu, 0);
        check("ar_busy0",    bus.o_busy,    0);
        check("ar_credit1",  cr(1),         0);
        check("ar_credit2",  cr(2),         0);
        #2 rst_n = 1'b1;
        set_done(1'b1, 2, 6);
        step();
        set_done(1'b0, 0, 0);
        check("ar_debit", cr(2),      -6);
        check("ar_idle",  bus.o_busy, 0);
        check("ar_nopop", bus.o_pop,  0);
        step();
        check("ar_nopop2", bus.o_pop, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trico_credit_arbiter.md
TRICO_CREDIT_ARBITER -- requirements
Module: trico_credit_arbiter

Interface
REQ-001 Parameter NUM_RPU, default 3, is the number of sub-tree pop units (RPUs); RPU 0 is the root and is never arbitrated.
REQ-002 Parameter PLW, default 7, is the packet length width.
REQ-003 Parameter CDW, default 16, is the signed per-RPU credit width.
REQ-004 Parameter RID_W, default $clog2(NUM_RPU), is the RPU index width.
REQ-005 Port i_clk  input  1  is the single clock; all state changes on its rising edge.
REQ-006 Port i_arst_n  input  1  is the reset, asynchronous and active-low.
REQ-007 Port i_credit_valid  input  1  carries a root-pop credit grant this cycle.
REQ-008 Port i_credit_rpu  input  RID_W  is the RPU receiving the credit.
REQ-009 Port i_credit_len  input  PLW  is the credit amount, unsigned.
REQ-010 Port i_done_valid  input  1  reports completion of a sub-tree pop.
REQ-011 Port i_done_rpu  input  RID_W  is the RPU that completed.
REQ-012 Port i_done_len  input  PLW  is the popped packet length, unsigned.
REQ-013 Port i_rpu_nonempty  input  NUM_RPU  flags RPUs that hold at least one entry.
REQ-014 Port o_pop  output  NUM_RPU  is a one-hot, single-cycle pop strobe; bit 0 is never set.
REQ-015 Port o_pop_rpu  output  RID_W  is the index of the strobed RPU; 0 when o_pop is 0.
REQ-016 Port o_credit  output  NUM_RPU*CDW  is the packed per-RPU credit, RPU i at bits [i*CDW +: CDW].
REQ-017 Port o_busy  output  NUM_RPU  flags RPUs with a pop outstanding.

Function
REQ-018 Each RPU i>=1 SHALL run a 2-state FSM: IDLE and WAIT.
REQ-019 RPU i is eligible when it is IDLE, i_rpu_nonempty[i]=1 and credit[i]>0 as a signed value.
REQ-020 At most one RPU SHALL be granted per cycle, selected round-robin starting from the RPU after the last granted one, wrapping from NUM_RPU-1 to 1.
REQ-021 A grant SHALL assert o_pop and o_pop_rpu on the cycle after eligibility is sampled (1-cycle latency, registered outputs), and move that RPU to WAIT.
REQ-022 WAIT -> IDLE SHALL occur on i_done_valid with i_done_rpu=i; the RPU is not eligible again before the following cycle.
REQ-023 Credit update per cycle: credit[i] += i_credit_len if credit targets i; credit[i] -= i_done_len if done targets i; both applied in the same cycle when they coincide.
REQ-024 Arithmetic SHALL use CDW+1-bit signed intermediates with zero-extended lengths.
REQ-025 Credit or done aimed at RPU 0 or an index >= NUM_RPU SHALL be ignored.
REQ-026 i_done_valid for an IDLE RPU SHALL debit credit but leave the state unchanged.
REQ-027 An RPU whose nonempty flag drops while WAIT SHALL stay in WAIT until its done.
REQ-028 o_busy[i] SHALL equal (state[i]==WAIT).

Reset
REQ-029 On i_arst_n=0, asynchronously: all FSMs IDLE, all credits 0, round-robin pointer at RPU 1, o_pop=0, o_pop_rpu=0, o_busy=0.
REQ-030 Reset asserted while pops are outstanding SHALL discard them; a later i_done_valid for them SHALL only debit credit (per REQ-026).

Configuration
REQ-031 Macro TRICO_CREDIT_SAT_EN defined: credit updates SHALL saturate at +2^(CDW-1)-1 and -2^(CDW-1).
REQ-032 Macro TRICO_CREDIT_SAT_EN undefined: credit updates SHALL wrap modulo 2^CDW.

Verification
REQ-033 Reset, then credit 10 to RPU 1 with nonempty[1]=1 -> o_pop=3'b010, o_pop_rpu=1 one cycle after credit becomes visible, o_busy[1]=1.
REQ-034 RPU 1 in WAIT, done len 12 -> credit[1]=-2, RPU 1 IDLE, no further pop until credit 3 arrives (credit 1 -> pop).
REQ-035 RPUs 1 and 2 both eligible continuously with done returned each grant -> grants alternate 1,2,1,2.
REQ-036 Same-cycle credit 5 and done 7 on RPU 2 with credit[2]=4 -> credit[2]=2.
REQ-037 With TRICO_CREDIT_SAT_EN, credit 32767 plus credit 100 -> 32767; without it, -32669.
REQ-038 Reset pulsed while RPU 2 in WAIT -> all outputs 0 immediately; subsequent done on RPU 2 -> credit[2]=-len, no pop.
